// File: rtl/seq_alu.sv
// Handshaked ALU with registered results and an iterative shift-add multiplier.
// Non-MUL ops complete in one cycle; MUL takes WIDTH cycles in MUL_BUSY.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       Ctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             Zero,
  output logic             Overflow,
  output logic             Cout
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MUL_BUSY = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [1:0] SPARE    = 2'd3;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_SLLV = 3'd5;
  localparam logic [2:0] OP_SRAV = 3'd6;
  localparam logic [2:0] OP_SRLV = 3'd7;

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic [1:0]         state;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_next;

  logic               accept;
  logic               is_sub;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   res;
  logic               res_ovf;
  logic               res_cout;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign acc_next  = acc + (mplier[0] ? mcand : '0);

  // SUB reuses the adder as A + ~B + 1 so Cout means "no borrow"
  always_comb begin
    is_sub   = (Ctl == OP_SUB);
    b_eff    = is_sub ? ~B : B;
    sum      = {1'b0, A} + {1'b0, b_eff}
             + {{WIDTH{1'b0}}, is_sub};
    shamt    = B[SHW-1:0];
    res      = '0;
    res_ovf  = 1'b0;
    res_cout = 1'b0;
    case (Ctl)
      OP_ADD, OP_SUB: begin
        res      = sum[WIDTH-1:0];
        res_cout = sum[WIDTH];
        res_ovf  = (A[WIDTH-1] == b_eff[WIDTH-1])
                 & (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_XOR:  res = A ^ B;
      OP_SLT:  res = {{(WIDTH-1){1'b0}},
                      $signed(A) < $signed(B)};
      OP_SLLV: res = A << shamt;
      OP_SRAV: res = $unsigned($signed(A) >>> shamt);
      OP_SRLV: res = A >> shamt;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out      <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      Cout     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
    end else if (accept && Ctl == OP_MUL) begin
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
      cnt    <= '0;
      state  <= MUL_BUSY;
    end else if (accept) begin
      out      <= res;
      Zero     <= (res == '0);
      Overflow <= res_ovf;
      Cout     <= res_cout;
      state    <= DONE;
    end else if (state == MUL_BUSY) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) begin
        out      <= acc_next[WIDTH-1:0];
        Zero     <= (acc_next[WIDTH-1:0] == '0);
        Overflow <= |acc_next[2*WIDTH-1:WIDTH];
        Cout     <= 1'b0;
        state    <= DONE;
      end
    end else if ((state == DONE && out_ready)
                 || state == SPARE) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: vector table with scoreboard,
// backpressure/handoff, async reset mid-MUL, and a WIDTH=8 instance.
module tb_seq_alu;

  typedef struct {
    string       nm;
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        z;
    logic        o;
    logic        c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        iv32, ir32, ov32, ordy32;
  logic [2:0]  ctl32;
  logic [31:0] a32, b32, out32;
  logic        z32, o32, c32;

  logic        iv8, ir8, ov8, ordy8;
  logic [2:0]  ctl8;
  logic [7:0]  a8, b8, out8;
  logic        z8, o8, c8;

  int   n_checks = 0;
  int   n_fail = 0;
  vec_t tv[16];
  vec_t q32[$];
  vec_t mon_e;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) d32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv32), .in_ready(ir32), .Ctl(ctl32),
    .A(a32), .B(b32),
    .out_valid(ov32), .out_ready(ordy32), .out(out32),
    .Zero(z32), .Overflow(o32), .Cout(c32)
  );

  seq_alu #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .Ctl(ctl8),
    .A(a8), .B(b8),
    .out_valid(ov8), .out_ready(ordy8), .out(out8),
    .Zero(z8), .Overflow(o8), .Cout(c8)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ov32 && ordy32) begin
      if (q32.size() == 0) begin
        chk("unexpected_result", 64'(out32), 64'hDEAD);
      end else begin
        mon_e = q32.pop_front();
        chk({mon_e.nm, "_out"}, 64'(out32), 64'(mon_e.out));
        chk({mon_e.nm, "_zero"}, 64'(z32), 64'(mon_e.z));
        chk({mon_e.nm, "_ovf"}, 64'(o32), 64'(mon_e.o));
        chk({mon_e.nm, "_cout"}, 64'(c32), 64'(mon_e.c));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send32(input vec_t v);
    logic got;
    got   = 1'b0;
    iv32  = 1'b1;
    ctl32 = v.ctl;
    a32   = v.a;
    b32   = v.b;
    q32.push_back(v);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = ir32;
      @(posedge clk);
      #1;
    end
    iv32  = 1'b0;
    ctl32 = 3'($urandom);
    a32   = $urandom;
    b32   = $urandom;
    if (!got) chk({v.nm, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_out32(input int exp_lat, input string nm);
    int n;
    int rdy_busy;
    n        = 1;
    rdy_busy = 0;
    while (!ov32 && n < 100) begin
      if (ir32) rdy_busy++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
    chk({nm, "_ready_busy"}, 64'(rdy_busy), 64'd0);
  endtask

  task automatic op8(input string nm, input logic [2:0] c,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eo, input logic eovf,
                     input int elat);
    int n;
    ctl8 = c;
    a8   = a;
    b8   = b;
    iv8  = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, 64'(ir8), 64'd1);
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    a8  = 8'hA5;
    b8  = 8'h5A;
    n   = 1;
    while (!ov8 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(elat));
    chk({nm, "_out"}, 64'(out8), 64'(eo));
    chk({nm, "_ovf"}, 64'(o8), 64'(eovf));
    chk({nm, "_zero"}, 64'(z8), 64'(eo == 8'h00));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got 0 want 1");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t v;
    int   busy_valid;
    tv[0]  = '{"add_ovf", 3'd0, 32'h7FFFFFFF, 32'h1,
               32'h80000000, 1'b0, 1'b1, 1'b0};
    tv[1]  = '{"sub_eq", 3'd1, 32'd5, 32'd5,
               32'h0, 1'b1, 1'b0, 1'b1};
    tv[2]  = '{"sub_borrow", 3'd1, 32'd0, 32'd1,
               32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{"slt_neg", 3'd3, 32'h80000000, 32'h1,
               32'h1, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{"slt_pos", 3'd3, 32'h1, 32'h80000000,
               32'h0, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{"srav_hi", 3'd6, 32'hF0000000, 32'h104,
               32'hFF000000, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{"sllv_31", 3'd5, 32'h1, 32'd31,
               32'h80000000, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{"srlv_31", 3'd7, 32'h80000000, 32'd31,
               32'h1, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{"mul_ovf", 3'd4, 32'h10000, 32'h10000,
               32'h0, 1'b1, 1'b1, 1'b0};
    tv[9]  = '{"mul_small", 3'd4, 32'd12345, 32'd678,
               32'd8369910, 1'b0, 1'b0, 1'b0};
    tv[10] = '{"add_carry", 3'd0, 32'hFFFFFFFF, 32'h1,
               32'h0, 1'b1, 1'b0, 1'b1};
    tv[11] = '{"xor", 3'd2, 32'hFF00, 32'h0FF0,
               32'hF0F0, 1'b0, 1'b0, 1'b0};
    tv[12] = '{"sub_ovf", 3'd1, 32'h80000000, 32'h1,
               32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
    tv[13] = '{"slt_wrap", 3'd3, 32'h80000000, 32'h7FFFFFFF,
               32'h1, 1'b0, 1'b0, 1'b0};
    tv[14] = '{"srav_zero", 3'd6, 32'h12345678, 32'h20,
               32'h12345678, 1'b0, 1'b0, 1'b0};
    tv[15] = '{"mul_max", 3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'h1, 1'b0, 1'b1, 1'b0};

    rst_n  = 1'b0;
    iv32   = 1'b0;
    ordy32 = 1'b1;
    ctl32  = 3'd0;
    a32    = '0;
    b32    = '0;
    iv8    = 1'b0;
    ordy8  = 1'b1;
    ctl8   = 3'd0;
    a8     = '0;
    b8     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 64'(out32), 64'd0);
    chk("rst_valid", 64'(ov32), 64'd0);
    chk("rst_flags", 64'({z32, o32, c32}), 64'd0);
    chk("rst_out8", 64'(out8), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(ir32), 64'd1);

    for (int i = 0; i < 16; i++) begin
      send32(tv[i]);
      wait_out32((tv[i].ctl == 3'd4) ? 33 : 1, tv[i].nm);
    end
    @(posedge clk);
    #1;
    chk("table_drained", 64'(q32.size()), 64'd0);

    // Backpressure then same-edge handoff
    ordy32 = 1'b0;
    v = '{"bp_add", 3'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0};
    send32(v);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(ov32), 64'd1);
      chk("bp_out", 64'(out32), 64'd7);
      chk("bp_flags", 64'({z32, o32, c32}), 64'd0);
      chk("bp_in_ready", 64'(ir32), 64'd0);
      @(posedge clk);
      #1;
    end
    ordy32 = 1'b1;
    v = '{"handoff_xor", 3'd2, 32'hFF00, 32'h0FF0,
          32'hF0F0, 1'b0, 1'b0, 1'b0};
    send32(v);
    wait_out32(1, "handoff");
    chk("handoff_out", 64'(out32), 64'hF0F0);
    @(posedge clk);
    #1;

    // Reset mid-MUL
    v = '{"mul_abandon", 3'd4, 32'd3, 32'd5, 32'd15,
          1'b0, 1'b0, 1'b0};
    send32(v);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", 64'(out32), 64'd0);
    chk("arst_valid", 64'(ov32), 64'd0);
    chk("arst_flags", 64'({z32, o32, c32}), 64'd0);
    q32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(ir32), 64'd1);
    busy_valid = 0;
    repeat (40) begin
      if (ov32) busy_valid++;
      @(posedge clk);
      #1;
    end
    chk("abandoned_no_result", 64'(busy_valid), 64'd0);
    v = '{"post_rst_add", 3'd0, 32'd2, 32'd3, 32'd5,
          1'b0, 1'b0, 1'b0};
    send32(v);
    wait_out32(1, "post_rst_add");
    @(posedge clk);
    #1;
    chk("final_drained", 64'(q32.size()), 64'd0);

    op8("w8_mul", 3'd4, 8'h10, 8'h10, 8'h00, 1'b1, 9);
    op8("w8_sllv", 3'd5, 8'h01, 8'h0F, 8'h80, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
